// File: rtl/pwm_pkg.sv
// Shared types, constants and decode helpers for the PWM output controller.
// Imported by the timebase and the top-level channel mux.
package pwm_pkg;

  localparam int unsigned NUM_CH    = 16;
  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned PWM_STEPS = 256;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_OFF  = 8'h00;
  localparam duty_t DUTY_FULL = 8'hFF;
  localparam duty_t STEP_LAST = duty_t'(PWM_STEPS - 1);

  // What a single output pin is doing, decoded from its two enable bits.
  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_STATIC = 2'd1,
    CH_PWM    = 2'd2
  } ch_mode_e;

  // Output enable dominates: a channel with en_out low is off whatever en_pwm says.
  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    ch_mode_e mode;
    if (!en_out) begin
      mode = CH_OFF;
    end else if (!en_pwm) begin
      mode = CH_STATIC;
    end else begin
      mode = CH_PWM;
    end
    return mode;
  endfunction

  // 0xFF is forced fully on; a plain compare would leave one low step per period.
  function automatic logic pwm_level(input duty_t step, input duty_t duty);
    logic level;
    if (duty == DUTY_OFF) begin
      level = 1'b0;
    end else if (duty == DUTY_FULL) begin
      level = 1'b1;
    end else begin
      level = (step < duty);
    end
    return level;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit step counter; flags the period boundary combinationally
// and as a registered one-clk period_start pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 13,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  output duty_t step_cnt_o,
  output logic  boundary_o,
  output logic  period_start_o
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
  localparam duty_t                 STEP_ONE   = duty_t'(1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  duty_t                 step_q, step_d;
  logic                  period_start_q, period_start_d;
  logic                  step_tick;
  logic                  boundary;

  // NOTE: every variable driven here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d        = presc_q + PRESC_ONE;
    step_d         = step_q;
    step_tick      = (presc_q == PRESC_LAST);
    boundary       = step_tick && (step_q == STEP_LAST);
    period_start_d = boundary;
    if (step_tick) begin
      presc_d = '0;
      step_d  = step_q + STEP_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their next-state values from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      step_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      step_q         <= step_d;
      period_start_q <= period_start_d;
    end
  end

  assign step_cnt_o     = step_q;
  assign boundary_o     = boundary;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_output_ctrl.sv
// 16-channel output stage: off / static-high / shared PWM per channel, with the
// duty value shadowed so it only changes at a period boundary.
module pwm_output_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 13,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  duty_t             step_cnt;
  logic              boundary;
  duty_t             duty_shadow_q, duty_shadow_d;
  logic              pwm_raw;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [NUM_CH-1:0] out_q, out_d;

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .step_cnt_o     (step_cnt),
    .boundary_o     (boundary),
    .period_start_o (period_start)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Mid-period duty writes are ignored until the wrap, so pulses are never cut short.
  always_comb begin
    duty_shadow_d = duty_shadow_q;
    if (boundary) begin
      duty_shadow_d = pwm_duty_cycle;
    end
  end

  assign pwm_raw = pwm_level(step_cnt, duty_shadow_q);

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (ch_mode(en_out[i], en_pwm[i]))
        CH_OFF:    out_d[i] = 1'b0;
        CH_STATIC: out_d[i] = 1'b1;
        CH_PWM:    out_d[i] = pwm_raw;
        default:   out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q <= DUTY_OFF;
      out_q         <= '0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      out_q         <= out_d;
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// Bench for pwm_output_ctrl: two instances (PRESCALE 1 and 4) share stimulus and
// are checked every cycle against a time-based model, plus pinned literal values.
`timescale 1ns/1ps
module tb_pwm_output_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en_out_lo = '0, en_out_hi = '0, en_pwm_lo = '0, en_pwm_hi = '0;
  logic [7:0] duty = '0;

  logic [7:0] uo1, uio1, uo4, uio4;
  logic       ps1, ps4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pwm_output_ctrl #(.PRESCALE(1), .PRESCALE_W(16)) dut1 (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (en_out_lo), .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0 (en_pwm_lo), .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle (duty),
    .uo_out (uo1), .uio_out (uio1), .period_start (ps1)
  );

  pwm_output_ctrl #(.PRESCALE(4), .PRESCALE_W(16)) dut4 (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (en_out_lo), .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0 (en_pwm_lo), .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle (duty),
    .uo_out (uo4), .uio_out (uio4), .period_start (ps4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: after n clock edges since reset release the step count is (n/P) mod 256,
  // a boundary happens on every edge that is a multiple of 256*P, and the pins
  // show the channel rule applied to the state just before each edge.
  int          n_edges [2] = '{0, 0};
  logic [7:0]  shadow  [2] = '{8'h00, 8'h00};
  logic [15:0] exp_out [2] = '{16'h0, 16'h0};
  logic        exp_ps  [2] = '{1'b0, 1'b0};

  function automatic int pre_of(input int j);
    return (j == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        n_edges[j] = 0;
        shadow[j]  = 8'h00;
        exp_out[j] = 16'h0;
        exp_ps[j]  = 1'b0;
      end else begin
        int   step;
        logic level;
        step = (n_edges[j] / pre_of(j)) % 256;
        if (shadow[j] == 8'h00)      level = 1'b0;
        else if (shadow[j] == 8'hFF) level = 1'b1;
        else                         level = (step < int'(shadow[j]));
        exp_out[j] = {en_out_hi, en_out_lo} & (~{en_pwm_hi, en_pwm_lo} | {16{level}});
        n_edges[j]++;
        exp_ps[j] = (n_edges[j] % (256 * pre_of(j))) == 0;
        if (exp_ps[j]) shadow[j] = duty;
      end
    end
  end

  always @(negedge clk) begin
    check("uo_p1",  uo1,  exp_out[0][7:0]);
    check("uio_p1", uio1, exp_out[0][15:8]);
    check("ps_p1",  ps1,  exp_ps[0]);
    check("uo_p4",  uo4,  exp_out[1][7:0]);
    check("uio_p4", uio4, exp_out[1][15:8]);
    check("ps_p4",  ps4,  exp_ps[1]);
  end

  // Waits for a period_start pulse on the chosen instance, bounded.
  task automatic wait_ps(input bit on4);
    bit seen = 1'b0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(negedge clk);
      seen = on4 ? ps4 : ps1;
    end
    if (!seen) check("ps_timeout", 32'd0, 32'd1);
  endtask

  // Counts uo1[0] highs over the 256 cycles that follow a period_start.
  task automatic measure(output int hi, output logic first_bit);
    hi = 0;
    first_bit = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1) first_bit = uo1[0];
      hi += int'(uo1[0]);
    end
  endtask

  initial begin
    int   first1, first4, hi, hi4;
    logic fb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_uo",  uo1, 8'h00);
    check("reset_uio", uio1, 8'h00);
    check("reset_ps",  ps1, 1'b0);

    // First boundary lands 256*PRESCALE edges after release.
    rst_n = 1'b1;
    first1 = -1;
    first4 = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (ps1 && first1 < 0) first1 = k;
      if (ps4 && first4 < 0) first4 = k;
    end
    check("first_ps_p1", first1, 256);
    check("first_ps_p4", first4, 1024);

    // Static enables, then drop the upper byte.
    en_out_lo = 8'hFF; en_out_hi = 8'hFF;
    @(negedge clk);
    check("static_uo",  uo1,  8'hFF);
    check("static_uio", uio1, 8'hFF);
    en_out_hi = 8'h00;
    @(negedge clk);
    check("drop_uio", uio1, 8'h00);
    check("keep_uo",  uo1,  8'hFF);

    // Channel 0 on PWM at half duty.
    en_out_lo = 8'h01; en_pwm_lo = 8'h01; duty = 8'h80;
    wait_ps(1'b0);
    measure(hi, fb);
    check("duty80_high", hi, 128);
    check("duty80_rise", fb, 1'b1);
    check("other_bits",  uo1[7:1], 7'h00);

    duty = 8'h00; wait_ps(1'b0); measure(hi, fb);
    check("duty00_high", hi, 0);
    duty = 8'hFF; wait_ps(1'b0); measure(hi, fb);
    check("dutyFF_high", hi, 256);
    duty = 8'h01; wait_ps(1'b0); measure(hi, fb);
    check("duty01_high", hi, 1);
    check("duty01_first", fb, 1'b1);

    // Mid-period duty write must wait for the next boundary.
    duty = 8'h40;
    wait_ps(1'b0);
    hi = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 10) duty = 8'hC0;
      hi += int'(uo1[0]);
    end
    check("old_duty_held", hi, 64);
    check("ps_at_wrap", ps1, 1'b1);
    measure(hi, fb);
    check("new_duty_high", hi, 192);

    // Asynchronous reset in the middle of the PRESCALE=4 high phase.
    duty = 8'h80;
    wait_ps(1'b1);
    repeat (20) @(negedge clk);
    check("p4_high_before_rst", uo4[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_uo_p4", uo4, 8'h00);
    check("async_uo_p1", uo1, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first4 = -1;
    hi4 = 0;
    for (int k = 1; k <= 1100 && first4 < 0; k++) begin
      @(negedge clk);
      if (ps4) first4 = k;
      hi4 += int'(uo4[0]);
    end
    check("post_rst_ps_p4", first4, 1024);
    check("post_rst_low_p4", hi4, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
